// File: rtl/keybd_cmd_decoder.sv
// PS/2 scan-code command decoder: strips break/extended prefixes, suppresses typematic
// repeats and drives play/pause, direction and a stretched restart pulse.
module keybd_cmd_decoder #(
    parameter int                  CODE_W      = 8,
    parameter logic [CODE_W-1:0]   KEY_PLAY    = 8'h24,
    parameter logic [CODE_W-1:0]   KEY_PAUSE   = 8'h23,
    parameter logic [CODE_W-1:0]   KEY_RESTART = 8'h2D,
    parameter logic [CODE_W-1:0]   KEY_FWD     = 8'h2B,
    parameter logic [CODE_W-1:0]   KEY_BWD     = 8'h32,
    parameter logic [CODE_W-1:0]   BREAK_CODE  = 8'hF0,
    parameter logic [CODE_W-1:0]   EXT_CODE    = 8'hE0,
    parameter int                  RESTART_LEN = 4
) (
    input  logic              clck,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] scan_code,
    output logic              playing,
    output logic              direction,
    output logic              restart_pulse,
    output logic              cmd_event,
    output logic [2:0]        last_cmd
);

    localparam int NKEYS = 5;
    localparam int CNT_W = $clog2(RESTART_LEN + 1);
    // Key table ordered by match priority: index 0 wins over higher indices.
    localparam logic [NKEYS*CODE_W-1:0] KEY_VEC = {KEY_BWD, KEY_FWD, KEY_RESTART, KEY_PAUSE, KEY_PLAY};
    localparam int IDX_PLAY    = 0;
    localparam int IDX_PAUSE   = 1;
    localparam int IDX_RESTART = 2;
    localparam int IDX_FWD     = 3;
    localparam int IDX_BWD     = 4;

    typedef enum logic {IDLE = 1'b0, BRK_PEND = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [NKEYS-1:0]   held_q, held_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               playing_q, playing_d;
    logic               direction_q, direction_d;
    logic               cmd_event_q, cmd_event_d;
    logic [2:0]         last_cmd_q, last_cmd_d;

    logic [NKEYS-1:0]   match;
    logic [NKEYS-1:0]   sel;
    logic               is_brk;
    logic               is_ext;
    logic               accept;
    logic               release_key;
    logic [2:0]         cmd_code;

    generate
        for (genvar gi = 0; gi < NKEYS; gi++) begin : g_match
            assign match[gi] = (scan_code == KEY_VEC[gi*CODE_W +: CODE_W]);
        end
    endgenerate

    // Isolate the lowest set bit so duplicate key codes resolve by priority.
    assign sel    = match & ~(match - NKEYS'(1));
    assign is_brk = (scan_code == BREAK_CODE);
    assign is_ext = (scan_code == EXT_CODE);

    always_comb begin
        cmd_code = 3'd0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (sel[i]) cmd_code = 3'(i + 1);
        end
    end

    // State register
    always_ff @(posedge clck) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (code_valid) begin
            case (state_q)
                IDLE:     if (is_brk) state_d = BRK_PEND;
                BRK_PEND: if (!is_brk && !is_ext) state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Output / datapath next-value logic
    always_comb begin
        accept      = code_valid && (state_q == IDLE) && !is_brk && !is_ext
                      && (|sel) && !(|(sel & held_q));
        release_key = code_valid && (state_q == BRK_PEND) && !is_brk && !is_ext;

        held_d      = held_q;
        playing_d   = playing_q;
        direction_d = direction_q;
        last_cmd_d  = last_cmd_q;
        cmd_event_d = accept;
        cnt_d       = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;

        if (release_key) held_d = held_q & ~sel;

        if (accept) begin
            held_d     = held_q | sel;
            last_cmd_d = cmd_code;
            if (sel[IDX_PLAY])    playing_d   = 1'b1;
            if (sel[IDX_PAUSE])   playing_d   = 1'b0;
            if (sel[IDX_RESTART]) cnt_d       = CNT_W'(RESTART_LEN);
            if (sel[IDX_FWD])     direction_d = 1'b1;
            if (sel[IDX_BWD])     direction_d = 1'b0;
        end
    end

    always_ff @(posedge clck) begin
        if (reset) begin
            held_q      <= '0;
            cnt_q       <= '0;
            playing_q   <= 1'b0;
            direction_q <= 1'b1;
            cmd_event_q <= 1'b0;
            last_cmd_q  <= 3'd0;
        end else begin
            held_q      <= held_d;
            cnt_q       <= cnt_d;
            playing_q   <= playing_d;
            direction_q <= direction_d;
            cmd_event_q <= cmd_event_d;
            last_cmd_q  <= last_cmd_d;
        end
    end

    assign playing       = playing_q;
    assign direction     = direction_q;
    assign restart_pulse = (cnt_q != '0);
    assign cmd_event     = cmd_event_q;
    assign last_cmd      = last_cmd_q;

endmodule

// File: tb/tb_keybd_cmd_decoder.sv
// Directed bench for keybd_cmd_decoder: inputs change and outputs are sampled on negedge.
module tb_keybd_cmd_decoder;

    logic       clck = 1'b0;
    logic       reset = 1'b1;
    logic       code_valid = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       playing, direction, restart_pulse, cmd_event;
    logic [2:0] last_cmd;

    int checks = 0;
    int errors = 0;

    keybd_cmd_decoder dut (
        .clck          (clck),
        .reset         (reset),
        .code_valid    (code_valid),
        .scan_code     (scan_code),
        .playing       (playing),
        .direction     (direction),
        .restart_pulse (restart_pulse),
        .cmd_event     (cmd_event),
        .last_cmd      (last_cmd)
    );

    always #5 clck = ~clck;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one byte for one cycle; called and returns at a negedge.
    task automatic send(input logic [7:0] b);
        code_valid = 1'b1;
        scan_code  = b;
        @(negedge clck);
        code_valid = 1'b0;
        $display("tx byte=%02h playing=%0b dir=%0b pulse=%0b event=%0b last=%0d",
                 b, playing, direction, restart_pulse, cmd_event, last_cmd);
    endtask

    initial begin
        // 1. reset
        reset = 1'b1;
        repeat (3) @(negedge clck);
        reset = 1'b0;
        @(negedge clck);
        chk("rst_playing", {7'd0, playing}, 8'd0);
        chk("rst_dir", {7'd0, direction}, 8'd1);
        chk("rst_pulse", {7'd0, restart_pulse}, 8'd0);
        chk("rst_event", {7'd0, cmd_event}, 8'd0);
        chk("rst_last", {5'd0, last_cmd}, 8'd0);

        // 2. play, typematic repeats, release and re-press
        send(8'h24);
        chk("play_playing", {7'd0, playing}, 8'd1);
        chk("play_event", {7'd0, cmd_event}, 8'd1);
        chk("play_last", {5'd0, last_cmd}, 8'd1);
        @(negedge clck);
        chk("play_event_1cyc", {7'd0, cmd_event}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            send(8'h24);
            chk("repeat_no_event", {7'd0, cmd_event}, 8'd0);
        end
        send(8'hF0);
        chk("brk_no_event", {7'd0, cmd_event}, 8'd0);
        send(8'h24);
        chk("release_no_event", {7'd0, cmd_event}, 8'd0);
        chk("release_playing", {7'd0, playing}, 8'd1);
        send(8'h24);
        chk("repress_event", {7'd0, cmd_event}, 8'd1);
        chk("repress_last", {5'd0, last_cmd}, 8'd1);

        // 3. restart pulse exactly 4 cycles
        send(8'h2D);
        chk("rst_cmd_event", {7'd0, cmd_event}, 8'd1);
        chk("rst_cmd_last", {5'd0, last_cmd}, 8'd3);
        for (int i = 0; i < 4; i++) begin
            chk("pulse_high", {7'd0, restart_pulse}, 8'd1);
            chk("pulse_playing", {7'd0, playing}, 8'd1);
            @(negedge clck);
        end
        chk("pulse_low", {7'd0, restart_pulse}, 8'd0);

        // retrigger: release R, then R again at pulse cycle 3 -> 7 continuous cycles
        send(8'hF0);
        send(8'h2D);
        send(8'h2D);
        chk("retrig_p1", {7'd0, restart_pulse}, 8'd1);
        send(8'hF0);
        chk("retrig_p2", {7'd0, restart_pulse}, 8'd1);
        send(8'h2D);
        chk("retrig_p3", {7'd0, restart_pulse}, 8'd1);
        chk("retrig_held_event", {7'd0, cmd_event}, 8'd0);
        send(8'h2D);
        chk("retrig_p4", {7'd0, restart_pulse}, 8'd1);
        chk("retrig_event", {7'd0, cmd_event}, 8'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clck);
            chk("retrig_tail", {7'd0, restart_pulse}, 8'd1);
        end
        @(negedge clck);
        chk("retrig_end", {7'd0, restart_pulse}, 8'd0);
        chk("retrig_playing", {7'd0, playing}, 8'd1);

        // 4. break of a never-pressed key, then pause
        send(8'hF0);
        send(8'h23);
        chk("nonheld_brk_event", {7'd0, cmd_event}, 8'd0);
        chk("nonheld_brk_playing", {7'd0, playing}, 8'd1);
        chk("nonheld_brk_last", {5'd0, last_cmd}, 8'd3);
        send(8'h23);
        chk("pause_playing", {7'd0, playing}, 8'd0);
        chk("pause_last", {5'd0, last_cmd}, 8'd2);
        chk("pause_event", {7'd0, cmd_event}, 8'd1);

        // 5. extended prefix dropped, fwd/bwd, unknown key
        send(8'hE0);
        chk("ext_no_event", {7'd0, cmd_event}, 8'd0);
        send(8'h2B);
        chk("fwd_dir", {7'd0, direction}, 8'd1);
        chk("fwd_last", {5'd0, last_cmd}, 8'd4);
        chk("fwd_event", {7'd0, cmd_event}, 8'd1);
        send(8'h32);
        chk("bwd_dir", {7'd0, direction}, 8'd0);
        chk("bwd_last", {5'd0, last_cmd}, 8'd5);
        send(8'h1C);
        chk("unknown_event", {7'd0, cmd_event}, 8'd0);
        chk("unknown_last", {5'd0, last_cmd}, 8'd5);
        chk("unknown_dir", {7'd0, direction}, 8'd0);

        // 6. reset clears pending break and held keys
        send(8'hF0);
        reset = 1'b1;
        @(negedge clck);
        chk("rst2_dir", {7'd0, direction}, 8'd1);
        chk("rst2_last", {5'd0, last_cmd}, 8'd0);
        reset = 1'b0;
        send(8'h24);
        chk("after_rst_playing", {7'd0, playing}, 8'd1);
        chk("after_rst_event", {7'd0, cmd_event}, 8'd1);

        // reset during a restart pulse
        send(8'h2D);
        chk("pre_rst_pulse", {7'd0, restart_pulse}, 8'd1);
        @(negedge clck);
        reset = 1'b1;
        @(negedge clck);
        chk("rst_mid_pulse", {7'd0, restart_pulse}, 8'd0);
        chk("rst_mid_playing", {7'd0, playing}, 8'd0);
        chk("rst_mid_last", {5'd0, last_cmd}, 8'd0);
        reset = 1'b0;
        @(negedge clck);
        chk("post_rst_pulse", {7'd0, restart_pulse}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
